// File: rtl/bp_pkg.sv
// bp_pkg: BTB entry layout, counter encodings and saturating counter helpers.
package bp_pkg;
  localparam int BTB_W = 32;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;
  typedef struct packed {
    logic valid;
    logic [BTB_W-1:0] tag;
    logic [BTB_W-1:0] target;
    logic [1:0] ctr;
  } btb_entry_t;
  localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
  function automatic logic [1:0] satInc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction
  function automatic logic [1:0] satDec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction
endpackage

// File: rtl/bp_table.sv
// bp_table: direct-mapped BTB storage with async reset, combinational reads and one synchronous write.
module bp_table
  import bp_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rdIdxF,
  output btb_entry_t       rdDataF,
  input  logic [IDX_W-1:0] rdIdxE,
  output btb_entry_t       rdDataE,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  btb_entry_t       wrData
);
  btb_entry_t mem [2**IDX_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 2**IDX_W; i++) mem[i] <= RESET_ENTRY;
    else if (wrEn) mem[wrIdx] <= wrData;
  assign rdDataF = mem[rdIdxF];
  assign rdDataE = mem[rdIdxE];
endmodule

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: BTB-based next-PC prediction, Execute-stage mispredict/flush detection and table training.
module branch_pred_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  output logic [XLEN-1:0] PCNextF,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE,
  output logic            FlushD,
  output logic            FlushE,
  output logic [31:0]     BrCount,
  output logic [31:0]     MispredCount
);
  btb_entry_t rdF, rdE, wrData;
  logic [IDX_W-1:0] idxF, idxE;
  logic [BTB_W-1:0] tagF, tagE;
  logic hitF, hitE, resolveE, wrEn;
  logic [31:0] brCount, mispredCount;
  assign idxF = IDX_W'(PCF >> 2);
  assign idxE = IDX_W'(PCE >> 2);
  assign tagF = BTB_W'(PCF >> (IDX_W + 2));
  assign tagE = BTB_W'(PCE >> (IDX_W + 2));
  bp_table #(.IDX_W(IDX_W)) table_i (
    .clk(clk), .rst_n(rst_n),
    .rdIdxF(idxF), .rdDataF(rdF),
    .rdIdxE(idxE), .rdDataE(rdE),
    .wrEn(wrEn), .wrIdx(idxE), .wrData(wrData)
  );
  assign hitF = rdF.valid && rdF.tag == tagF;
  assign hitE = rdE.valid && rdE.tag == tagE;
  assign resolveE = BranchE | JumpE;
  assign PredTakenF = hitF && rdF.ctr[1];
  assign PredTargetF = XLEN'(rdF.target);
  assign MispredictE = resolveE && ((PCSrcE != PredTakenE) || (PCSrcE && PredTakenE && PCTargetE != PredTargetE));
  assign FlushD = MispredictE;
  assign FlushE = MispredictE;
  assign PCNextF = MispredictE ? (PCSrcE ? PCTargetE : PCPlus4E) : PredTakenF ? PredTargetF : PCF + XLEN'(4);
  // A miss only allocates on a taken outcome; hits always retrain in place.
  assign wrEn = resolveE && (hitE || PCSrcE);
  always_comb begin
    wrData.valid = 1'b1;
    wrData.tag = tagE;
    wrData.target = (JumpE || PCSrcE) ? BTB_W'(PCTargetE) : rdE.target;
    wrData.ctr = JumpE ? ST : !hitE ? WT : PCSrcE ? satInc(rdE.ctr) : satDec(rdE.ctr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      brCount <= '0;
      mispredCount <= '0;
    end else begin
      if (resolveE && ~&brCount) brCount <= brCount + 32'd1;
      if (MispredictE && ~&mispredCount) mispredCount <= mispredCount + 32'd1;
    end
  assign BrCount = brCount;
  assign MispredCount = mispredCount;
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: directed checks of lookup, mispredict, training, aliasing, reset and counter saturation.
module tb_branch_pred_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] PCF, PredTargetF, PCNextF, PCE, PCTargetE, PCPlus4E, PredTargetE, BrCount, MispredCount;
  logic PredTakenF, BranchE, JumpE, PCSrcE, PredTakenE, MispredictE, FlushD, FlushE;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_pred_ctrl #(.IDX_W(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .PCNextF(PCNextF), .BranchE(BranchE), .JumpE(JumpE), .PCSrcE(PCSrcE), .PCE(PCE),
    .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .FlushD(FlushD), .FlushE(FlushE), .BrCount(BrCount),
    .MispredCount(MispredCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setE(input logic br, input logic jmp, input logic src, input logic [31:0] pce,
                      input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    BranchE = br; JumpE = jmp; PCSrcE = src; PCE = pce; PCTargetE = tgt;
    PCPlus4E = pce + 32'd4; PredTakenE = pt; PredTargetE = ptgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] pcf);
    setE(0, 0, 0, 0, 0, 0, 0);
    PCF = pcf;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(32'h100);
    chk("rst_pred", {31'b0, PredTakenF}, 0);
    chk("rst_next", PCNextF, 32'h104);
    chk("rst_br", BrCount, 0);
    chk("rst_mis", MispredCount, 0);
    chk("rst_mispredE", {31'b0, MispredictE}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_br", BrCount, 0);
    chk("idle_pred", {31'b0, PredTakenF}, 0);
    // cold taken branch at 0x40 -> 0x20
    setE(1, 0, 1, 32'h40, 32'h20, 0, 0); #1;
    chk("cold_mis", {31'b0, MispredictE}, 1);
    chk("cold_flushD", {31'b0, FlushD}, 1);
    chk("cold_flushE", {31'b0, FlushE}, 1);
    chk("cold_next", PCNextF, 32'h20);
    tick();
    idle(32'h40);
    chk("cold_pred", {31'b0, PredTakenF}, 1);
    chk("cold_tgt", PredTargetF, 32'h20);
    chk("cold_pnext", PCNextF, 32'h20);
    chk("cold_br", BrCount, 1);
    chk("cold_cnt", MispredCount, 1);
    // training from WT: T, T, N, N
    setE(1, 0, 1, 32'h40, 32'h20, 1, 32'h20); #1;
    chk("tr_t1_mis", {31'b0, MispredictE}, 0);
    tick(); idle(32'h40);
    chk("tr_t1_pred", {31'b0, PredTakenF}, 1);
    setE(1, 0, 1, 32'h40, 32'h20, 1, 32'h20); tick(); idle(32'h40);
    chk("tr_t2_pred", {31'b0, PredTakenF}, 1);
    setE(1, 0, 0, 32'h40, 32'h20, 1, 32'h20); #1;
    chk("tr_n1_mis", {31'b0, MispredictE}, 1);
    chk("tr_n1_next", PCNextF, 32'h44);
    tick(); idle(32'h40);
    chk("tr_n1_pred", {31'b0, PredTakenF}, 1);
    setE(1, 0, 0, 32'h40, 32'h20, 1, 32'h20); tick(); idle(32'h40);
    chk("tr_n2_pred", {31'b0, PredTakenF}, 0);
    chk("tr_n2_next", PCNextF, 32'h44);
    chk("tr_br", BrCount, 5);
    chk("tr_cnt", MispredCount, 3);
    // drive to SNT and past it, then back up
    setE(1, 0, 0, 32'h40, 32'h20, 0, 0); #1;
    chk("tr_n3_mis", {31'b0, MispredictE}, 0);
    tick();
    setE(1, 0, 0, 32'h40, 32'h20, 0, 0); tick();
    setE(1, 0, 1, 32'h40, 32'h20, 0, 0); tick(); idle(32'h40);
    chk("tr_snt_sat", {31'b0, PredTakenF}, 0);
    setE(1, 0, 1, 32'h40, 32'h20, 0, 0); tick(); idle(32'h40);
    chk("tr_wt_pred", {31'b0, PredTakenF}, 1);
    chk("tr2_br", BrCount, 9);
    chk("tr2_cnt", MispredCount, 5);
    // aliasing at index 0
    idle(32'h80);
    chk("al_pred0", {31'b0, PredTakenF}, 0);
    chk("al_next0", PCNextF, 32'h84);
    setE(1, 0, 1, 32'h80, 32'h30, 0, 0); #1;
    chk("al_nobypass", {31'b0, PredTakenF}, 0);
    chk("al_mis_next", PCNextF, 32'h30);
    tick(); idle(32'h80);
    chk("al_pred1", {31'b0, PredTakenF}, 1);
    chk("al_tgt1", PredTargetF, 32'h30);
    idle(32'h40);
    chk("al_evict", {31'b0, PredTakenF}, 0);
    chk("al_evict_next", PCNextF, 32'h44);
    // jalr target mismatch
    PCF = 32'h100;
    setE(0, 1, 1, 32'h80, 32'h24, 1, 32'h20); #1;
    chk("tm_mis", {31'b0, MispredictE}, 1);
    chk("tm_next", PCNextF, 32'h24);
    tick(); idle(32'h80);
    chk("tm_tgt", PredTargetF, 32'h24);
    chk("tm_pred", {31'b0, PredTakenF}, 1);
    PCF = 32'h100;
    setE(0, 1, 1, 32'h80, 32'h24, 1, 32'h24); #1;
    chk("ok_mis", {31'b0, MispredictE}, 0);
    chk("ok_next", PCNextF, 32'h104);
    tick();
    // mispredict overrides fetch prediction; not-taken miss does not allocate
    PCF = 32'h80;
    setE(1, 0, 0, 32'h200, 32'h300, 1, 32'h300); #1;
    chk("ov_mis", {31'b0, MispredictE}, 1);
    chk("ov_next", PCNextF, 32'h204);
    tick(); idle(32'h200);
    chk("nt_noalloc", {31'b0, PredTakenF}, 0);
    idle(32'h80);
    chk("nt_keep", {31'b0, PredTakenF}, 1);
    chk("ov_br", BrCount, 13);
    chk("ov_cnt", MispredCount, 8);
    // bubble: no resolve, no action
    setE(0, 0, 1, 32'h40, 32'h50, 0, 0); #1;
    chk("bub_mis", {31'b0, MispredictE}, 0);
    chk("bub_flush", {31'b0, FlushD}, 0);
    tick();
    chk("bub_br", BrCount, 13);
    // asynchronous reset mid-resolution
    PCF = 32'h80;
    setE(1, 0, 1, 32'h44, 32'h60, 0, 0);
    rst_n = 1'b0; #1;
    chk("mr_pred", {31'b0, PredTakenF}, 0);
    chk("mr_br", BrCount, 0);
    chk("mr_next", PCNextF, 32'h60);
    tick();
    rst_n = 1'b1;
    idle(32'h44);
    chk("mr_lost", {31'b0, PredTakenF}, 0);
    chk("mr_next2", PCNextF, 32'h48);
    tick();
    chk("mr_br2", BrCount, 0);
    // saturation of BrCount
    force dut.brCount = 32'hFFFF_FFFF;
    #1;
    release dut.brCount;
    #1;
    chk("sat_pre", BrCount, 32'hFFFF_FFFF);
    setE(1, 0, 0, 32'h48, 32'h70, 0, 0);
    tick();
    chk("sat_br", BrCount, 32'hFFFF_FFFF);
    chk("sat_mis", MispredCount, 0);
    idle(32'h100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
